reg_read_ctrl: RTL

Decode-stage register-read and operand-hazard controller for the 5-stage pipeline (F, D, X, M, W). It maps each decoded instruction to register-file read addresses and tracks the destinations of the three in-flight instructions in X, M and W. From those it produces registered bypass selects for the X-stage operand muxes and a combinational load-use stall. It is the read-side counterpart of the writeback enable logic and applies the same write rules.

---
 rtl/isa_defs.sv | 45 ++++
 rtl/reg_use_decode.sv | 72 +++++++
 rtl/reg_read_ctrl.sv | 82 ++++++++
 3 files changed

// File: rtl/isa_defs.sv
// Shared ISA definitions: opcode encodings, special registers, bypass select codes
// and the hazard-tracker entry used by the decode-stage controllers.
package isa_defs;

   localparam logic [4:0] OP_ALU  = 5'b00000;
   localparam logic [4:0] OP_J    = 5'b00001;
   localparam logic [4:0] OP_BNE  = 5'b00010;
   localparam logic [4:0] OP_JAL  = 5'b00011;
   localparam logic [4:0] OP_JR   = 5'b00100;
   localparam logic [4:0] OP_ADDI = 5'b00101;
   localparam logic [4:0] OP_BLT  = 5'b00110;
   localparam logic [4:0] OP_SW   = 5'b00111;
   localparam logic [4:0] OP_LW   = 5'b01000;
   localparam logic [4:0] OP_SETX = 5'b10101;
   localparam logic [4:0] OP_BEX  = 5'b10110;

   localparam logic [4:0] REG_RA     = 5'd31;
   localparam logic [4:0] REG_STATUS = 5'd30;

   localparam logic [1:0] SEL_RF = 2'b00;
   localparam logic [1:0] SEL_XM = 2'b01;
   localparam logic [1:0] SEL_MW = 2'b10;
   localparam logic [1:0] SEL_WB = 2'b11;

   typedef struct packed {
      logic       valid;
      logic [4:0] dest;
      logic       is_lw;
   } trk_entry_t;

   // Youngest producer first; r0 and unused operands always come from the register file.
   function automatic logic [1:0] pick_sel(input logic use_src, input logic [4:0] src,
                                           input trk_entry_t ent_x, input trk_entry_t ent_m,
                                           input trk_entry_t ent_w);
      logic [1:0] sel;
      sel = SEL_RF;
      if (use_src && src != 5'd0) begin
         if (ent_x.valid && ent_x.dest == src)      sel = SEL_XM;
         else if (ent_m.valid && ent_m.dest == src) sel = SEL_MW;
         else if (ent_w.valid && ent_w.dest == src) sel = SEL_WB;
      end
      return sel;
   endfunction

endpackage

// File: rtl/reg_use_decode.sv
// Combinational decode of one instruction into its register reads, its write
// destination and whether it is a load.
module reg_use_decode
   import isa_defs::*;
(
   input  logic [4:0] opcode,
   input  logic [4:0] rd,
   input  logic [4:0] rs,
   input  logic [4:0] rt,
   output logic       use_a,
   output logic [4:0] addr_a,
   output logic       use_b,
   output logic [4:0] addr_b,
   output logic       writes,
   output logic [4:0] dest,
   output logic       is_lw
);

   always_comb begin
      use_a  = 1'b0;
      addr_a = 5'd0;
      use_b  = 1'b0;
      addr_b = 5'd0;
      writes = 1'b0;
      dest   = 5'd0;
      is_lw  = 1'b0;
      case (opcode)
         OP_ALU: begin
            use_a = 1'b1; addr_a = rs;
            use_b = 1'b1; addr_b = rt;
            writes = 1'b1; dest = rd;
         end
         OP_ADDI: begin
            use_a = 1'b1; addr_a = rs;
            writes = 1'b1; dest = rd;
         end
         OP_LW: begin
            use_a = 1'b1; addr_a = rs;
            writes = 1'b1; dest = rd;
            is_lw = 1'b1;
         end
         // sw reads its store data through the rd field.
         OP_SW: begin
            use_a = 1'b1; addr_a = rs;
            use_b = 1'b1; addr_b = rd;
         end
         OP_BNE, OP_BLT: begin
            use_a = 1'b1; addr_a = rd;
            use_b = 1'b1; addr_b = rs;
         end
         OP_JR: begin
            use_a = 1'b1; addr_a = rd;
         end
         OP_BEX: begin
            use_a = 1'b1; addr_a = REG_STATUS;
         end
         OP_JAL: begin
            writes = 1'b1; dest = REG_RA;
         end
         OP_SETX: begin
            writes = 1'b1; dest = REG_STATUS;
         end
         OP_J: begin
            use_a = 1'b0;
         end
         default: begin
            use_a = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/reg_read_ctrl.sv
// Decode-stage register-read and operand-hazard controller: drives register-file
// read addresses, the load-use stall and registered X-stage bypass selects.
module reg_read_ctrl
   import isa_defs::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       d_valid,
   input  logic [4:0] d_opcode,
   input  logic [4:0] d_rd,
   input  logic [4:0] d_rs,
   input  logic [4:0] d_rt,
   input  logic       flush,
   output logic [4:0] ctrl_readRegA,
   output logic [4:0] ctrl_readRegB,
   output logic       stall,
   output logic [1:0] x_sel_a,
   output logic [1:0] x_sel_b
);

   logic       use_a;
   logic       use_b;
   logic [4:0] addr_a;
   logic [4:0] addr_b;
   logic       writes;
   logic [4:0] dest;
   logic       is_lw;
   logic       load_use;
   logic       advance;
   trk_entry_t ent_x;
   trk_entry_t ent_m;
   trk_entry_t ent_w;

   reg_use_decode u_decode (
      .opcode (d_opcode),
      .rd     (d_rd),
      .rs     (d_rs),
      .rt     (d_rt),
      .use_a  (use_a),
      .addr_a (addr_a),
      .use_b  (use_b),
      .addr_b (addr_b),
      .writes (writes),
      .dest   (dest),
      .is_lw  (is_lw)
   );

   assign ctrl_readRegA = addr_a;
   assign ctrl_readRegB = addr_b;

   // Only a load sitting in X forces a stall; all older producers are bypassable.
   assign load_use = ent_x.valid && ent_x.is_lw &&
                     ((use_a && addr_a != 5'd0 && addr_a == ent_x.dest) ||
                      (use_b && addr_b != 5'd0 && addr_b == ent_x.dest));
   assign stall    = load_use && d_valid && !flush;
   assign advance  = d_valid && !stall && !flush;

   always_ff @(posedge clock) begin
      if (reset) begin
         ent_x   <= '0;
         ent_m   <= '0;
         ent_w   <= '0;
         x_sel_a <= SEL_RF;
         x_sel_b <= SEL_RF;
      end else begin
         ent_w <= ent_m;
         ent_m <= ent_x;
         if (advance) begin
            ent_x.valid <= writes && (dest != 5'd0);
            ent_x.dest  <= dest;
            ent_x.is_lw <= is_lw;
            x_sel_a     <= pick_sel(use_a, addr_a, ent_x, ent_m, ent_w);
            x_sel_b     <= pick_sel(use_b, addr_b, ent_x, ent_m, ent_w);
         end else begin
            ent_x   <= '0;
            x_sel_a <= SEL_RF;
            x_sel_b <= SEL_RF;
         end
      end
   end

endmodule
